// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and writeback request type for the register-file writer
//
// Purpose: width constants for the integer register file and the record carried
//          through the load-result queue.
// Contents:
//   XLEN              result / write-data width
//   REG_AW            register address width (2**REG_AW registers, x0 reads as zero)
//   NUM_REGS          number of architectural registers
//   LQ_DEPTH_DEFAULT  default load-result queue depth
//   wb_req_t          {rd, data} pair moved from a producer to the write port
//   is_writable       true for every destination except x0
package rv_pkg;

    localparam int XLEN             = 32;
    localparam int REG_AW           = 5;
    localparam int NUM_REGS         = 1 << REG_AW;
    localparam int LQ_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    function automatic logic is_writable(input logic [REG_AW-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/rf_writeback_if.sv
// rtl/rf_writeback_if.sv - result streams, regfile write port and hazard query bundle
//
// Purpose: groups every non-clock/reset signal of rf_writeback.
// Signals:
//   alloc_valid/alloc_rd           load issued, destination to mark busy
//   alu_valid/alu_rd/alu_data      ALU result offer, alu_ready back
//   ld_valid/ld_rd/ld_data         load result offer, ld_ready back
//   rf_write_enable/addr/data      registered regfile write port
//   chk1_addr/chk2_addr            hazard queries, chk1_busy/chk2_busy answers
// Modports: master = execute/memory/issue side, slave = rf_writeback.
interface rf_writeback_if;
    import rv_pkg::*;

    logic              alloc_valid;
    logic [REG_AW-1:0] alloc_rd;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_ready;

    logic              ld_valid;
    logic [REG_AW-1:0] ld_rd;
    logic [XLEN-1:0]   ld_data;
    logic              ld_ready;

    logic              rf_write_enable;
    logic [REG_AW-1:0] rf_write_addr;
    logic [XLEN-1:0]   rf_write_data;

    logic [REG_AW-1:0] chk1_addr;
    logic [REG_AW-1:0] chk2_addr;
    logic              chk1_busy;
    logic              chk2_busy;

    modport master (
        output alloc_valid, alloc_rd,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        input  rf_write_enable, rf_write_addr, rf_write_data,
        output chk1_addr, chk2_addr,
        input  chk1_busy, chk2_busy
    );

    modport slave (
        input  alloc_valid, alloc_rd,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        output rf_write_enable, rf_write_addr, rf_write_data,
        input  chk1_addr, chk2_addr,
        output chk1_busy, chk2_busy
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback requests
//
// Purpose: holds load results until the regfile write port is free.
// Ports:
//   clk       clock
//   reset     synchronous active-low reset, empties the FIFO
//   push      enqueue push_req (ignored when full)
//   push_req  request to enqueue
//   pop       dequeue head (ignored when empty)
//   head      oldest entry, valid while !empty
//   count     number of stored entries
//   full      count == DEPTH
//   empty     count == 0
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wb_req_t                      push_req,
    input  logic                         pop,
    output wb_req_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: entries are only visible through head while count > 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_req;
    end

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - regfile writer: ALU/load arbitration, write regs, busy scoreboard
//
// Purpose: merges ALU and load results onto the single regfile write port and tracks
//          destinations of outstanding loads so issue can stall on RAW hazards.
// Ports:
//   clk    clock
//   reset  synchronous active-low reset
//   bus    rf_writeback_if.slave: alloc, ALU and load streams, registered write
//          port, two hazard query ports
// Behaviour summary:
//   Queued loads always take the write port; the ALU is accepted only when the
//   load FIFO is empty. Writes to x0 complete the handshake but never strobe.
module rf_writeback
    import rv_pkg::*;
#(
    parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    rf_writeback_if.slave bus
);

    localparam int CNT_W = $clog2(LQ_DEPTH + 1);

    wb_req_t             ld_req;
    wb_req_t             head;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                alu_fire;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                we_q;
    logic [REG_AW-1:0]   addr_q;
    logic [XLEN-1:0]     data_q;
    logic                we_d;
    logic [REG_AW-1:0]   addr_d;
    logic [XLEN-1:0]     data_d;

    assign ld_req.rd   = bus.ld_rd;
    assign ld_req.data = bus.ld_data;

    // Readiness comes from registered state only, so neither ready depends on a valid.
    assign bus.ld_ready  = (fifo_count < CNT_W'(LQ_DEPTH));
    assign bus.alu_ready = fifo_empty;
    assign fifo_push     = bus.ld_valid && bus.ld_ready;
    assign fifo_pop      = !fifo_empty;
    assign alu_fire      = bus.alu_valid && fifo_empty;

    wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_ld_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_req (ld_req),
        .pop      (fifo_pop),
        .head     (head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_next = busy;

        if (fifo_pop) begin
            we_d            = is_writable(head.rd);
            addr_d          = head.rd;
            data_d          = head.data;
            busy_next[head.rd] = 1'b0;
        end else if (alu_fire) begin
            we_d   = is_writable(bus.alu_rd);
            addr_d = bus.alu_rd;
            data_d = bus.alu_data;
        end

        // Applied after the clear so a same-edge alloc of the popped rd stays busy.
        if (bus.alloc_valid && is_writable(bus.alloc_rd)) begin
            busy_next[bus.alloc_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy   <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy   <= busy_next;
        end
    end

    assign bus.rf_write_enable = we_q;
    assign bus.rf_write_addr   = addr_q;
    assign bus.rf_write_data   = data_q;

    // The write-register term covers the cycle before the regfile captures the value.
    assign bus.chk1_busy = is_writable(bus.chk1_addr) &&
                           (busy[bus.chk1_addr] || (we_q && addr_q == bus.chk1_addr));
    assign bus.chk2_busy = is_writable(bus.chk2_addr) &&
                           (busy[bus.chk2_addr] || (we_q && addr_q == bus.chk2_addr));

    // An ALU result aimed at a register awaiting a load breaks the issue contract.
    always_ff @(posedge clk) begin
        if (reset && alu_fire) begin
            assert (!busy[bus.alu_rd]);
        end
        if (reset) begin
            assert (fifo_full == (fifo_count == CNT_W'(LQ_DEPTH)));
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - self-checking bench for rf_writeback
module tb_rf_writeback;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    rf_writeback_if bus ();

    rf_writeback dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: queue of pending loads, busy set, expected write register.
    wb_req_t          m_q[$];
    bit               m_busy[NUM_REGS];
    bit               m_we;
    logic [4:0]       m_addr;
    logic [31:0]      m_data;
    logic [4:0]       wlog[$];
    logic [4:0]       outst[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit exp_busy(input logic [4:0] a);
        return (a != 0) && (m_busy[a] || (m_we && m_addr == a));
    endfunction

    function automatic bit in_outst(input logic [4:0] r);
        foreach (outst[i]) if (outst[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        bus.alloc_valid = 0;
        bus.alu_valid   = 0;
        bus.ld_valid    = 0;
    endtask

    // Called at a negedge with inputs applied; checks, advances model, returns at next negedge.
    task automatic tick();
        bit      e_ld_ready, e_alu_ready, acc_alu, acc_ld;
        wb_req_t h;
        #1;
        e_ld_ready  = m_q.size() < LQ_DEPTH_DEFAULT;
        e_alu_ready = m_q.size() == 0;
        check("ld_ready", bus.ld_ready, e_ld_ready);
        check("alu_ready", bus.alu_ready, e_alu_ready);
        check("we", bus.rf_write_enable, m_we);
        if (m_we) begin
            check("addr", bus.rf_write_addr, m_addr);
            check("data", bus.rf_write_data, m_data);
        end
        check("chk1_busy", bus.chk1_busy, exp_busy(bus.chk1_addr));
        check("chk2_busy", bus.chk2_busy, exp_busy(bus.chk2_addr));
        if (bus.rf_write_enable === 1'b1) wlog.push_back(bus.rf_write_addr);

        if (!reset) begin
            m_q.delete();
            foreach (m_busy[i]) m_busy[i] = 0;
            m_we = 0; m_addr = 0; m_data = 0;
        end else begin
            acc_alu = bus.alu_valid && e_alu_ready;
            acc_ld  = bus.ld_valid && e_ld_ready;
            if (m_q.size() > 0) begin
                h = m_q.pop_front();
                m_we = (h.rd != 0); m_addr = h.rd; m_data = h.data;
                m_busy[h.rd] = 0;
            end else if (acc_alu) begin
                m_we = (bus.alu_rd != 0); m_addr = bus.alu_rd; m_data = bus.alu_data;
            end else begin
                m_we = 0;
            end
            if (acc_ld) m_q.push_back('{rd: bus.ld_rd, data: bus.ld_data});
            if (bus.alloc_valid && bus.alloc_rd != 0) m_busy[bus.alloc_rd] = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] exp4[3];
        logic [4:0] exp6[4];
        logic [4:0] r;
        bit         ld_acc;
        exp4 = '{5'd3, 5'd6, 5'd4};
        exp6 = '{5'd11, 5'd12, 5'd13, 5'd8};

        // 1: reset held with every valid high
        reset = 0;
        bus.alloc_valid = 1; bus.alloc_rd = 3;
        bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h1;
        bus.ld_valid = 1; bus.ld_rd = 2; bus.ld_data = 32'h2;
        bus.chk1_addr = 3; bus.chk2_addr = 2;
        m_we = 0; m_addr = 0; m_data = 0;
        @(posedge clk);
        @(negedge clk);
        repeat (3) begin
            #1;
            check("rst_we", bus.rf_write_enable, 0);
            check("rst_addr", bus.rf_write_addr, 0);
            check("rst_data", bus.rf_write_data, 0);
            check("rst_chk1", bus.chk1_busy, 0);
            check("rst_chk2", bus.chk2_busy, 0);
            tick();
        end
        reset = 1;
        bus.alu_rd = 9; bus.ld_rd = 10; bus.alloc_rd = 10;
        #1;
        check("release_we", bus.rf_write_enable, 0);
        tick();
        idle();
        repeat (4) tick();

        // 2: single ALU write
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF; bus.chk1_addr = 5;
        #1;
        check("t2_alu_ready", bus.alu_ready, 1);
        check("t2_busy_n", bus.chk1_busy, 0);
        tick();
        idle();
        #1;
        check("t2_we", bus.rf_write_enable, 1);
        check("t2_addr", bus.rf_write_addr, 5);
        check("t2_data", bus.rf_write_data, 32'hDEADBEEF);
        check("t2_busy_n1", bus.chk1_busy, 1);
        tick();
        #1;
        check("t2_we_n2", bus.rf_write_enable, 0);
        check("t2_busy_n2", bus.chk1_busy, 0);
        tick();

        // 3: alloc x7, load returns three cycles later
        bus.alloc_valid = 1; bus.alloc_rd = 7; bus.chk1_addr = 7;
        tick();
        bus.alloc_valid = 0;
        for (int c = 1; c <= 6; c++) begin
            bus.ld_valid = (c == 3); bus.ld_rd = 7; bus.ld_data = 32'h00001234;
            #1;
            check($sformatf("t3_busy_n%0d", c), bus.chk1_busy, (c <= 5));
            check($sformatf("t3_we_n%0d", c), bus.rf_write_enable, (c == 5));
            if (c == 5) begin
                check("t3_addr", bus.rf_write_addr, 7);
                check("t3_data", bus.rf_write_data, 32'h00001234);
            end
            tick();
        end

        // 4: FIFO holds x3 when ALU x4 and load x6 are offered together
        bus.alloc_valid = 1; bus.alloc_rd = 3; tick();
        bus.alloc_rd = 6; tick();
        bus.alloc_valid = 0;
        bus.ld_valid = 1; bus.ld_rd = 3; bus.ld_data = 32'h33; tick();
        wlog.delete();
        bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 32'h44;
        bus.ld_rd = 6; bus.ld_data = 32'h66;
        #1; check("t4_alu_ready_a", bus.alu_ready, 0); tick();
        bus.ld_valid = 0;
        #1; check("t4_alu_ready_b", bus.alu_ready, 0); tick();
        #1; check("t4_alu_ready_c", bus.alu_ready, 1); tick();
        idle();
        repeat (2) tick();
        check("t4_nwrites", wlog.size(), 3);
        for (int i = 0; i < 3; i++) check($sformatf("t4_order%0d", i), wlog[i], exp4[i]);

        // 5: x0 destination
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFFFFFF;
        bus.alloc_valid = 1; bus.alloc_rd = 0; bus.chk1_addr = 0; bus.chk2_addr = 0;
        #1; check("t5_alu_ready", bus.alu_ready, 1); tick();
        idle();
        #1; check("t5_we", bus.rf_write_enable, 0); check("t5_busy", bus.chk1_busy, 0); tick();
        #1; check("t5_we2", bus.rf_write_enable, 0); tick();

        // 6: three back-to-back loads beat a held ALU result
        for (int i = 0; i < 3; i++) begin
            bus.alloc_valid = 1; bus.alloc_rd = 5'(11 + i); tick();
        end
        bus.alloc_valid = 0;
        wlog.delete();
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1; bus.ld_rd = 5'(11 + i); bus.ld_data = $urandom;
            bus.alu_valid = (i > 0); bus.alu_rd = 8; bus.alu_data = 32'h88;
            #1;
            check($sformatf("t6_ld_ready%0d", i), bus.ld_ready, 1);
            if (i > 0) check($sformatf("t6_alu_ready%0d", i), bus.alu_ready, 0);
            tick();
        end
        bus.ld_valid = 0;
        #1; check("t6_alu_hold", bus.alu_ready, 0); tick();
        #1; check("t6_alu_go", bus.alu_ready, 1); tick();
        idle();
        repeat (2) tick();
        check("t6_nwrites", wlog.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t6_order%0d", i), wlog[i], exp6[i]);

        // Random traffic against the model, with occasional resets
        repeat (3000) begin
            idle();
            reset = ($urandom_range(0, 149) != 0);
            if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
                bus.ld_valid = 1; bus.ld_rd = outst[0]; bus.ld_data = $urandom;
            end
            if (outst.size() < 4 && $urandom_range(0, 2) == 0) begin
                r = 5'($urandom_range(0, 31));
                if (r == 0 || (!m_busy[r] && !in_outst(r))) begin
                    bus.alloc_valid = 1; bus.alloc_rd = r;
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                r = 5'($urandom_range(0, 31));
                if (r == 0 || (!m_busy[r] && !in_outst(r))) begin
                    bus.alu_valid = 1; bus.alu_rd = r; bus.alu_data = $urandom;
                end
            end
            bus.chk1_addr = ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom_range(0, 31));
            bus.chk2_addr = (outst.size() > 0) ? outst[$] : 5'($urandom_range(0, 31));
            ld_acc = bus.ld_valid && (m_q.size() < LQ_DEPTH_DEFAULT);
            tick();
            if (!reset) begin
                outst.delete();
            end else begin
                if (ld_acc) void'(outst.pop_front());
                if (bus.alloc_valid) outst.push_back(bus.alloc_rd);
            end
        end
        reset = 1;
        idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
